// File: rtl/parity_arb_pkg.sv
// Shared types and constants for the parity arbiter slice: FSM state, requester limit, counter width.
// Pure declarations; no latency or backpressure of its own.
package parity_arb_pkg;

    localparam int MAX_REQ = 8;
    localparam int CNT_W   = 16;
    localparam int WORD_W  = 3;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

endpackage

// File: rtl/parity_arbiter_if.sv
// Requester-side valid/ready bundle plus the single response port; slave is the arbiter side.
// Wires only: no latency; backpressure is carried by req_ready_o and rsp_ready_i.
interface parity_arbiter_if
    import parity_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
);

    logic [NUM_REQ-1:0]             req_valid_i;
    logic [NUM_REQ-1:0][WORD_W-1:0] req_data_i;
    logic [NUM_REQ-1:0]             req_ready_o;
    logic                           rsp_valid_o;
    logic                           rsp_ready_i;
    logic [ID_W-1:0]                rsp_id_o;
    logic                           rsp_parity_o;

    modport slave (
        input  req_valid_i, req_data_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_id_o, rsp_parity_o
    );

    modport master (
        output req_valid_i, req_data_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_id_o, rsp_parity_o
    );

endinterface

// File: rtl/parity_arbiter_design4.sv
// Existing shared 3-bit odd-parity unit (module design4); output is 1 for an odd count of ones.
// Purely combinational, no backpressure; enable is active-low and forces the output low when high.
module design4 (
    input  logic       enable,
    input  logic [2:0] data_in,
    output logic       data_out
);

    assign data_out = ~enable & (^data_in);

endmodule

// File: rtl/parity_arbiter.sv
// Round-robin arbiter sharing one design4 parity unit; 1-cycle grant-to-response latency, 1 result/cycle.
// A held response (rsp_ready_i low) closes the grant window; optional PARITY_ARB_CNT_EN adds done_cnt_o.
module parity_arbiter
    import parity_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
`ifdef PARITY_ARB_CNT_EN
    output logic [CNT_W-1:0] done_cnt_o,
`endif
    parity_arbiter_if.slave  bus
);

    state_e            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic              rsp_par_q, rsp_par_d;
    logic [ID_W-1:0]   grant_idx;
    logic              grant;
    logic              unit_en_n;
    logic [WORD_W-1:0] unit_dat;
    logic              unit_par;

    // First valid index at or after ptr, wrapping modulo NUM_REQ.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                                input logic [ID_W-1:0]    ptr);
        logic [ID_W-1:0] pick;
        logic [ID_W-1:0] cand;
        logic            found;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && vld[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign grant_idx = rr_pick(bus.req_valid_i, rr_ptr_q);
    assign grant     = rst_ni && (|bus.req_valid_i) && ((state_q == IDLE) || bus.rsp_ready_i);

    design4 u_parity (
        .enable   (unit_en_n),
        .data_in  (unit_dat),
        .data_out (unit_par)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant) state_d = RESP;
            RESP:    if (grant) state_d = RESP;
                     else if (bus.rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready_o  = '0;
        unit_en_n        = 1'b1;
        unit_dat         = '0;
        if (grant) begin
            bus.req_ready_o[grant_idx] = 1'b1;
            unit_en_n                  = 1'b0;
            unit_dat                   = bus.req_data_i[grant_idx];
        end
        bus.rsp_valid_o  = (state_q == RESP);
        bus.rsp_id_o     = rsp_id_q;
        bus.rsp_parity_o = rsp_par_q;
    end

    always_comb begin
        rsp_id_d  = rsp_id_q;
        rsp_par_d = rsp_par_q;
        rr_ptr_d  = rr_ptr_q;
        if (grant) begin
            rsp_id_d  = grant_idx;
            rsp_par_d = unit_par;
            rr_ptr_d  = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_ptr_q  <= '0;
            rsp_id_q  <= '0;
            rsp_par_q <= 1'b0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            rsp_id_q  <= rsp_id_d;
            rsp_par_q <= rsp_par_d;
        end
    end

`ifdef PARITY_ARB_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts response handshakes, sticking at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if ((state_q == RESP) && bus.rsp_ready_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_parity_arbiter.sv
// Directed bench for parity_arbiter with a response scoreboard; optional PARITY_ARB_CNT_EN checks done_cnt_o.
module tb_parity_arbiter;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    typedef struct packed {
        logic [1:0] id;
        logic       par;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    parity_arbiter_if #(.NUM_REQ(4)) bus ();

`ifdef PARITY_ARB_CNT_EN
    logic [15:0] done_cnt;
`endif

    parity_arbiter #(.NUM_REQ(4)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
`ifdef PARITY_ARB_CNT_EN
        .done_cnt_o (done_cnt),
`endif
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int id, input logic [2:0] w);
        exp_t e;
        e.id  = 2'(id);
        e.par = ^w;
        exp_q.push_back(e);
    endtask

    // Scoreboard: every response handshake must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid_o && bus.rsp_ready_i) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sb_id", 32'(bus.rsp_id_o), 32'(mon_e.id));
                chk("sb_par", 32'(bus.rsp_parity_o), 32'(mon_e.par));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] w [4];

        rst_n           = 1'b0;
        bus.req_valid_i = '0;
        bus.req_data_i  = '0;
        bus.rsp_ready_i = 1'b1;

        // Reset state, with a requester already valid.
        tick();
        bus.req_valid_i = 4'b0001;
        @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready_o), 32'h0);
        chk("rst_valid", 32'(bus.rsp_valid_o), 32'h0);
        chk("rst_id", 32'(bus.rsp_id_o), 32'h0);
        chk("rst_par", 32'(bus.rsp_parity_o), 32'h0);

        // Single request.
        tick();
        rst_n = 1'b1;
        bus.req_data_i[0] = 3'b111;
        @(negedge clk);
        chk("single_ready", 32'(bus.req_ready_o), 32'b0001);
        push(0, 3'b111);
        tick();
        bus.req_valid_i = '0;
        @(negedge clk);
        chk("single_vld", 32'(bus.rsp_valid_o), 32'h1);
        chk("single_id", 32'(bus.rsp_id_o), 32'h0);
        chk("single_par", 32'(bus.rsp_parity_o), 32'h1);
        tick();
        @(negedge clk);
        chk("idle_vld", 32'(bus.rsp_valid_o), 32'h0);

        // Restart from pointer 0, then all four requesters at once.
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        w[0] = 3'b001; w[1] = 3'b011; w[2] = 3'b100; w[3] = 3'b000;
        for (int i = 0; i < 4; i++) bus.req_data_i[i] = w[i];
        bus.req_valid_i = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rr_ready", 32'(bus.req_ready_o), 32'(1) << i);
            push(i, w[i]);
            tick();
            bus.req_valid_i[i] = 1'b0;
        end
        @(negedge clk);
        chk("rr_last_id", 32'(bus.rsp_id_o), 32'h3);
        tick();
        @(negedge clk);
        chk("rr_drain_vld", 32'(bus.rsp_valid_o), 32'h0);

        // Backpressure for three cycles while requester 1 waits.
        tick();
        bus.req_data_i[0] = 3'b110;
        bus.req_valid_i   = 4'b0001;
        @(negedge clk);
        chk("bp_grant", 32'(bus.req_ready_o), 32'b0001);
        push(0, 3'b110);
        tick();
        bus.req_valid_i   = 4'b0010;
        bus.req_data_i[1] = 3'b111;
        bus.rsp_ready_i   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_vld", 32'(bus.rsp_valid_o), 32'h1);
            chk("bp_id", 32'(bus.rsp_id_o), 32'h0);
            chk("bp_par", 32'(bus.rsp_parity_o), 32'h0);
            chk("bp_ready", 32'(bus.req_ready_o), 32'h0);
            tick();
        end
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        chk("release_ready", 32'(bus.req_ready_o), 32'b0010);
        push(1, 3'b111);
        tick();
        bus.req_valid_i = '0;
        @(negedge clk);
        chk("release_id", 32'(bus.rsp_id_o), 32'h1);
        tick();

        // Fairness: grant 2, then 1 and 3 together.
        bus.req_data_i[2] = 3'b010;
        bus.req_valid_i   = 4'b0100;
        @(negedge clk);
        chk("fair_g2", 32'(bus.req_ready_o), 32'b0100);
        push(2, 3'b010);
        tick();
        bus.req_data_i[1] = 3'b001;
        bus.req_data_i[3] = 3'b011;
        bus.req_valid_i   = 4'b1010;
        @(negedge clk);
        chk("fair_first", 32'(bus.req_ready_o), 32'b1000);
        push(3, 3'b011);
        tick();
        bus.req_valid_i = 4'b0010;
        @(negedge clk);
        chk("fair_second", 32'(bus.req_ready_o), 32'b0010);
        push(1, 3'b001);
        tick();
        bus.req_data_i[2] = 3'b111;
        bus.req_valid_i   = 4'b0111;
        @(negedge clk);
        chk("ptr_probe", 32'(bus.req_ready_o), 32'b0100);
        push(2, 3'b111);
        tick();
        bus.req_valid_i = 4'b0011;
        bus.rsp_ready_i = 1'b0;
        @(negedge clk);
        chk("held_vld", 32'(bus.rsp_valid_o), 32'h1);
        chk("held_id", 32'(bus.rsp_id_o), 32'h2);

        // Reset while a response is held: it is dropped without handshake.
        tick();
        rst_n = 1'b0;
        chk("q_before_rst", 32'(exp_q.size()), 32'd1);
        exp_q.delete();
        @(negedge clk);
        chk("midrst_ready", 32'(bus.req_ready_o), 32'h0);
        tick();
        rst_n = 1'b1;
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        chk("post_rst_vld", 32'(bus.rsp_valid_o), 32'h0);
        chk("post_rst_grant", 32'(bus.req_ready_o), 32'b0001);
        push(0, 3'b110);
        tick();
        bus.req_valid_i = 4'b0010;
        @(negedge clk);
        chk("post_rst_next", 32'(bus.req_ready_o), 32'b0010);
        push(1, 3'b001);
        tick();
        bus.req_valid_i = '0;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("q_empty", 32'(exp_q.size()), 32'd0);

`ifdef PARITY_ARB_CNT_EN
        for (int i = 0; i < 3; i++) begin
            tick();
            bus.req_valid_i = 4'b0001;
            @(negedge clk);
            push(0, 3'b110);
            tick();
            bus.req_valid_i = '0;
            @(negedge clk);
        end
        tick();
        @(negedge clk);
        chk("cnt_five", 32'(done_cnt), 32'd5);
        tick();
        bus.req_valid_i = 4'b0001;
        for (int i = 0; i < 65540; i++) begin
            @(negedge clk);
            push(0, 3'b110);
            tick();
        end
        bus.req_valid_i = '0;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("cnt_sat", 32'(done_cnt), 32'hFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
